layer_batch_sequencer: RTL and testbench

LAYER_BATCH_SEQUENCER -- requirements
Module: layer_batch_sequencer

---
 rtl/layer_batch_sequencer.sv | 171 +++++++++++++++++
 tb/tb_layer_batch_sequencer.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/layer_batch_sequencer.sv
// Walks layers layer_first..effective last, running one load/schedule handshake per batch.
// Both wait states are guarded by a watchdog that parks the block in ERROR until reset.
module layer_batch_sequencer #(
   parameter int unsigned BATCHES_L0 = 8,
   parameter int unsigned BATCHES_L1 = 8,
   parameter int unsigned BATCHES_L2 = 4,
   parameter int unsigned BATCHES_L3 = 2,
   parameter int unsigned WDOG_LIMIT = 1048575
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [1:0] layer_first,
   input  logic [1:0] layer_last,
   input  logic       load_done,
   input  logic       sched_done,
   output logic       load_req,
   output logic       sched_start,
   output logic [1:0] current_layer_id,
   output logic [2:0] current_batch_id,
   output logic       busy,
   output logic       layer_done,
   output logic       all_done,
   output logic       err
);

   // state       | meaning
   // IDLE        | waiting for start, ids hold last run's final values
   // LOAD_REQ    | one-cycle load_req pulse for the current batch
   // LOAD_WAIT   | waiting for load_done, watchdog running
   // SCHED_START | one-cycle sched_start pulse
   // SCHED_WAIT  | waiting for sched_done, watchdog running
   // NEXT        | advance batch/layer or finish
   // FINISH      | layer_done + all_done pulse, back to IDLE
   // ERROR       | watchdog expired, held until reset
   typedef enum logic [2:0] {
      IDLE, LOAD_REQ, LOAD_WAIT, SCHED_START, SCHED_WAIT, NEXT, FINISH, ERROR
   } state_t;

   localparam logic [19:0] WDOG_LOAD = 20'(WDOG_LIMIT - 1);

   state_t      state_q;
   logic [1:0]  layer_q;
   logic [1:0]  last_q;
   logic [2:0]  batch_q;
   logic [19:0] wdog_q;
   logic        load_req_q;
   logic        sched_start_q;
   logic        busy_q;
   logic        layer_done_q;
   logic        all_done_q;
   logic        err_q;
   logic [2:0]  last_batch_d;

   function automatic logic [2:0] last_batch(input logic [1:0] layer);
      case (layer)
         2'd0:    last_batch = 3'(BATCHES_L0 - 1);
         2'd1:    last_batch = 3'(BATCHES_L1 - 1);
         2'd2:    last_batch = 3'(BATCHES_L2 - 1);
         default: last_batch = 3'(BATCHES_L3 - 1);
      endcase
   endfunction

   always_comb begin
      last_batch_d = last_batch(layer_q);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         layer_q       <= 2'd0;
         last_q        <= 2'd0;
         batch_q       <= 3'd0;
         wdog_q        <= 20'd0;
         load_req_q    <= 1'b0;
         sched_start_q <= 1'b0;
         busy_q        <= 1'b0;
         layer_done_q  <= 1'b0;
         all_done_q    <= 1'b0;
         err_q         <= 1'b0;
      end else begin
         load_req_q    <= 1'b0;
         sched_start_q <= 1'b0;
         layer_done_q  <= 1'b0;
         all_done_q    <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  layer_q    <= layer_first;
                  // A reversed range collapses to a single-layer run.
                  last_q     <= (layer_last < layer_first) ? layer_first : layer_last;
                  batch_q    <= 3'd0;
                  state_q    <= LOAD_REQ;
                  load_req_q <= 1'b1;
                  busy_q     <= 1'b1;
               end
            end
            LOAD_REQ: begin
               state_q <= LOAD_WAIT;
               wdog_q  <= WDOG_LOAD;
            end
            LOAD_WAIT: begin
               if (load_done) begin
                  state_q       <= SCHED_START;
                  sched_start_q <= 1'b1;
               end else if (wdog_q == 20'd0) begin
                  state_q <= ERROR;
                  busy_q  <= 1'b0;
                  err_q   <= 1'b1;
               end else begin
                  wdog_q <= wdog_q - 20'd1;
               end
            end
            SCHED_START: begin
               state_q <= SCHED_WAIT;
               wdog_q  <= WDOG_LOAD;
            end
            SCHED_WAIT: begin
               if (sched_done) begin
                  state_q <= NEXT;
               end else if (wdog_q == 20'd0) begin
                  state_q <= ERROR;
                  busy_q  <= 1'b0;
                  err_q   <= 1'b1;
               end else begin
                  wdog_q <= wdog_q - 20'd1;
               end
            end
            NEXT: begin
               if (batch_q < last_batch_d) begin
                  batch_q    <= batch_q + 3'd1;
                  state_q    <= LOAD_REQ;
                  load_req_q <= 1'b1;
               end else if (layer_q < last_q) begin
                  layer_q      <= layer_q + 2'd1;
                  batch_q      <= 3'd0;
                  state_q      <= LOAD_REQ;
                  load_req_q   <= 1'b1;
                  layer_done_q <= 1'b1;
               end else begin
                  state_q      <= FINISH;
                  layer_done_q <= 1'b1;
                  all_done_q   <= 1'b1;
               end
            end
            FINISH: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
            ERROR: begin
               busy_q <= 1'b0;
               err_q  <= 1'b1;
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign load_req         = load_req_q;
   assign sched_start      = sched_start_q;
   assign current_layer_id = layer_q;
   assign current_batch_id = batch_q;
   assign busy             = busy_q;
   assign layer_done       = layer_done_q;
   assign all_done         = all_done_q;
   assign err              = err_q;

endmodule

// File: tb/tb_layer_batch_sequencer.sv
// Directed bench for layer_batch_sequencer: expected (layer,batch) per load_req are queued
// at start and matched against what the DUT presents; counts and timing checked per run.
module tb_layer_batch_sequencer;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [1:0] layer_first;
   logic [1:0] layer_last;
   logic       load_done;
   logic       sched_done;
   logic       load_req;
   logic       sched_start;
   logic [1:0] current_layer_id;
   logic [2:0] current_batch_id;
   logic       busy;
   logic       layer_done;
   logic       all_done;
   logic       err;

   logic ld_model = 1'b0;
   logic sd_model = 1'b0;
   logic ld_man, sd_man, ld_en, sd_en;
   int   ld_cnt = 0;
   int   sd_cnt = 0;

   assign load_done  = ld_model | ld_man;
   assign sched_done = sd_model | sd_man;

   int checks = 0;
   int passes = 0;
   int fails  = 0;

   logic [4:0] exp_q[$];
   logic [4:0] obs_mem [0:63];
   int obs_wr = 0;
   int obs_rd = 0;
   int ss_cnt = 0;
   int ldn_cnt = 0;
   int ad_cnt = 0;
   int both_cnt = 0;
   int cyc = 0;
   int sd_cyc = 0;
   int last_gap = 0;
   logic [4:0] ld_ids = 5'd0;

   layer_batch_sequencer #(.WDOG_LIMIT(100)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .start            (start),
      .layer_first      (layer_first),
      .layer_last       (layer_last),
      .load_done        (load_done),
      .sched_done       (sched_done),
      .load_req         (load_req),
      .sched_start      (sched_start),
      .current_layer_id (current_layer_id),
      .current_batch_id (current_batch_id),
      .busy             (busy),
      .layer_done       (layer_done),
      .all_done         (all_done),
      .err              (err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Loader and scheduler models: answer three cycles after their request pulse.
   always @(posedge clk) begin
      #1;
      ld_model = 1'b0;
      sd_model = 1'b0;
      if (!rst_n) begin
         ld_cnt = 0;
         sd_cnt = 0;
      end else begin
         if (ld_cnt != 0) begin
            ld_cnt--;
            if (ld_cnt == 0) ld_model = ld_en;
         end
         if (sd_cnt != 0) begin
            sd_cnt--;
            if (sd_cnt == 0) sd_model = sd_en;
         end
         if (load_req) ld_cnt = 3;
         if (sched_start) sd_cnt = 3;
      end
   end

   always @(negedge clk) begin
      cyc++;
      if (rst_n) begin
         if (sched_done) sd_cyc = cyc;
         if (load_req) begin
            obs_mem[obs_wr[5:0]] = {current_layer_id, current_batch_id};
            obs_wr++;
            last_gap = cyc - sd_cyc;
         end
         if (sched_start) ss_cnt++;
         if (layer_done) ldn_cnt++;
         if (all_done) ad_cnt++;
         if (layer_done && all_done) both_cnt++;
         if (layer_done && !all_done) ld_ids = {current_layer_id, current_batch_id};
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) passes++;
      else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic push_layer(input logic [1:0] l, input int n);
      for (int b = 0; b < n; b++) exp_q.push_back({l, 3'(b)});
   endtask

   task automatic do_start(input string tag, input logic [1:0] f, input logic [1:0] l);
      step();
      layer_first = f;
      layer_last  = l;
      start       = 1'b1;
      step();
      start = 1'b0;
      chk({tag, "_latency"}, 32'(load_req), 1);
      chk({tag, "_busy"}, 32'(busy), 1);
   endtask

   task automatic wait_all_done(input string tag, input int budget);
      int base;
      int n;
      base = ad_cnt;
      n = 0;
      while (ad_cnt == base && n < budget) begin
         step();
         n++;
      end
      chk({tag, "_done_in_time"}, 32'(ad_cnt != base), 1);
   endtask

   task automatic check_run(input string tag);
      chk({tag, "_nload"}, 32'(obs_wr - obs_rd), 32'(exp_q.size()));
      while (exp_q.size() > 0 && obs_rd < obs_wr) begin
         chk({tag, "_ids"}, 32'(obs_mem[obs_rd[5:0]]), 32'(exp_q.pop_front()));
         obs_rd++;
      end
      exp_q.delete();
      obs_rd = obs_wr;
   endtask

   initial begin
      int s0, l0, a0, b0, w0, n;
      bit found;
      rst_n = 1'b0; start = 1'b0; layer_first = 2'd0; layer_last = 2'd0;
      ld_man = 1'b0; sd_man = 1'b0; ld_en = 1'b1; sd_en = 1'b1;
      repeat (3) step();
      chk("rst_load_req", 32'(load_req), 0);
      chk("rst_sched_start", 32'(sched_start), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_layer_done", 32'(layer_done), 0);
      chk("rst_all_done", 32'(all_done), 0);
      chk("rst_err", 32'(err), 0);
      chk("rst_ids", 32'({current_layer_id, current_batch_id}), 0);
      rst_n = 1'b1;
      repeat (5) step();
      chk("post_rst_quiet", 32'(obs_wr + ss_cnt + ldn_cnt + ad_cnt), 0);

      // Run A: layer 0 only, eight batches.
      s0 = ss_cnt; l0 = ldn_cnt; a0 = ad_cnt; b0 = both_cnt;
      push_layer(2'd0, 8);
      do_start("a", 2'd0, 2'd0);
      wait_all_done("a", 400);
      step(); step();
      check_run("a");
      chk("a_nsched", 32'(ss_cnt - s0), 8);
      chk("a_layer_done", 32'(ldn_cnt - l0), 1);
      chk("a_all_done", 32'(ad_cnt - a0), 1);
      chk("a_coincide", 32'(both_cnt - b0), 1);
      chk("a_gap", 32'(last_gap), 2);
      chk("a_hold_ids", 32'({current_layer_id, current_batch_id}), 32'({2'd0, 3'd7}));
      chk("a_idle_busy", 32'(busy), 0);

      // Run B: layers 2..3.
      s0 = ss_cnt; l0 = ldn_cnt; a0 = ad_cnt; b0 = both_cnt;
      push_layer(2'd2, 4);
      push_layer(2'd3, 2);
      do_start("b", 2'd2, 2'd3);
      wait_all_done("b", 400);
      step();
      check_run("b");
      chk("b_nsched", 32'(ss_cnt - s0), 6);
      chk("b_layer_done", 32'(ldn_cnt - l0), 2);
      chk("b_all_done", 32'(ad_cnt - a0), 1);
      chk("b_coincide", 32'(both_cnt - b0), 1);
      chk("b_mid_layer_done_ids", 32'(ld_ids), 32'({2'd3, 3'd0}));

      // Run C: reversed range runs layer 3 only.
      s0 = ss_cnt; l0 = ldn_cnt; a0 = ad_cnt;
      push_layer(2'd3, 2);
      do_start("c", 2'd3, 2'd1);
      wait_all_done("c", 400);
      step();
      check_run("c");
      chk("c_nsched", 32'(ss_cnt - s0), 2);
      chk("c_layer_done", 32'(ldn_cnt - l0), 1);
      chk("c_all_done", 32'(ad_cnt - a0), 1);
      chk("c_hold_ids", 32'({current_layer_id, current_batch_id}), 32'({2'd3, 3'd1}));

      // Run D: spurious handshakes and start while busy.
      ld_en = 1'b0; sd_en = 1'b0;
      push_layer(2'd1, 8);
      do_start("d", 2'd1, 2'd1);
      ld_man = 1'b1; step(); ld_man = 1'b0;
      sd_man = 1'b1; step(); sd_man = 1'b0;
      s0 = ss_cnt;
      repeat (3) step();
      chk("d_no_sched_start", 32'(ss_cnt - s0), 0);
      chk("d_ids_load_wait", 32'({current_layer_id, current_batch_id}), 32'({2'd1, 3'd0}));
      chk("d_busy_load_wait", 32'(busy), 1);
      ld_man = 1'b1; step(); ld_man = 1'b0;
      chk("d_sched_start", 32'(sched_start), 1);
      step();
      w0 = obs_wr; s0 = ss_cnt;
      layer_first = 2'd0; layer_last = 2'd3; start = 1'b1; ld_man = 1'b1;
      step();
      start = 1'b0; ld_man = 1'b0;
      repeat (3) step();
      chk("d_ids_sched_wait", 32'({current_layer_id, current_batch_id}), 32'({2'd1, 3'd0}));
      chk("d_no_load_req", 32'(obs_wr - w0), 0);
      chk("d_no_extra_sched", 32'(ss_cnt - s0), 0);
      chk("d_busy_sched_wait", 32'(busy), 1);
      ld_en = 1'b1; sd_en = 1'b1;
      sd_man = 1'b1; step(); sd_man = 1'b0;
      wait_all_done("d", 400);
      step();
      check_run("d");

      // Run E: reset while waiting on batch 5, then a clean restart.
      push_layer(2'd0, 6);
      do_start("e", 2'd0, 2'd0);
      found = 1'b0; n = 0;
      while (!found && n < 300) begin
         step();
         n++;
         if (sched_start && current_batch_id == 3'd5) found = 1'b1;
      end
      chk("e_reach_batch5", 32'(found), 1);
      step();
      rst_n = 1'b0;
      #1;
      chk("e_rst_busy", 32'(busy), 0);
      chk("e_rst_pulses", 32'({load_req, sched_start, layer_done, all_done}), 0);
      chk("e_rst_err", 32'(err), 0);
      chk("e_rst_ids", 32'({current_layer_id, current_batch_id}), 0);
      step(); step();
      check_run("e");
      rst_n = 1'b1;
      w0 = obs_wr; s0 = ss_cnt; l0 = ldn_cnt; a0 = ad_cnt;
      repeat (10) step();
      chk("e_quiet_after_rst", 32'((obs_wr - w0) + (ss_cnt - s0) + (ldn_cnt - l0) + (ad_cnt - a0)), 0);
      push_layer(2'd0, 8);
      do_start("f", 2'd0, 2'd0);
      wait_all_done("f", 400);
      step();
      check_run("f");

      // Run G: scheduler never answers, watchdog trips after 100 cycles.
      sd_en = 1'b0;
      push_layer(2'd2, 1);
      do_start("g", 2'd2, 2'd3);
      found = 1'b0; n = 0;
      while (!found && n < 50) begin
         step();
         n++;
         if (sched_start) found = 1'b1;
      end
      chk("g_reach_sched", 32'(found), 1);
      n = 0;
      while (!err && n < 200) begin
         step();
         n++;
      end
      chk("g_wdog_cycles", 32'(n), 101);
      chk("g_err", 32'(err), 1);
      chk("g_busy", 32'(busy), 0);
      w0 = obs_wr; s0 = ss_cnt;
      layer_first = 2'd0; layer_last = 2'd0; start = 1'b1;
      step();
      start = 1'b0;
      repeat (10) step();
      chk("g_start_ignored", 32'((obs_wr - w0) + (ss_cnt - s0)), 0);
      chk("g_err_sticky", 32'({err, busy}), 32'(2'b10));
      check_run("g");
      rst_n = 1'b0;
      step();
      chk("g_rst_clears_err", 32'(err), 0);
      rst_n = 1'b1;
      step();

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
